// File: rtl/bit_serializer_if.sv
// Parallel-in / serial-out bus for bit_serializer.
// The slave side is the serializer; the master side is whoever feeds words and watches the bit stream.
interface bit_serializer_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic             abort;
    logic             out_bit;
    logic             out_valid;
    logic             frame_start;
    logic             busy;

    modport master (
        output in_data, in_valid, abort,
        input  in_ready, out_bit, out_valid, frame_start, busy
    );

    modport slave (
        input  in_data, in_valid, abort,
        output in_ready, out_bit, out_valid, frame_start, busy
    );
endinterface

// File: rtl/bit_serializer.sv
// Word-to-bit serializer with a one-word holding buffer for gapless back-to-back frames.
// Idle cycles emit out_bit = 0 so a downstream sequence detector sees zeros between frames.
module bit_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input logic             clk,
    input logic             reset,
    bit_serializer_if.slave bus
);
    localparam int            CW       = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic {IDLE, SHIFT} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             hold_full_q, hold_full_d;
    logic             handshake;
    logic [WIDTH-1:0] shifted;

    assign handshake = bus.in_valid && !hold_full_q;
    assign shifted   = MSB_FIRST ? {shift_q[WIDTH-2:0], 1'b0} : {1'b0, shift_q[WIDTH-1:1]};

    assign bus.in_ready    = !hold_full_q;
    assign bus.out_valid   = (state_q == SHIFT);
    assign bus.out_bit     = (state_q == SHIFT) && (MSB_FIRST ? shift_q[WIDTH-1] : shift_q[0]);
    assign bus.frame_start = (state_q == SHIFT) && (cnt_q == CNT_LAST);
    assign bus.busy        = (state_q == SHIFT) || hold_full_q;

    always_comb begin
        // NOTE: every signal gets its hold value first so no path through the case infers a latch.
        state_d     = state_q;
        shift_d     = shift_q;
        cnt_d       = cnt_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;

        if (bus.abort) begin
            state_d     = IDLE;
            shift_d     = '0;
            cnt_d       = '0;
            hold_full_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (handshake) begin
                        shift_d = bus.in_data;
                        cnt_d   = CNT_LAST;
                        state_d = SHIFT;
                    end
                end
                SHIFT: begin
                    if (cnt_q != '0) begin
                        shift_d = shifted;
                        cnt_d   = cnt_q - CW'(1);
                        if (handshake) begin
                            hold_d      = bus.in_data;
                            hold_full_d = 1'b1;
                        end
                    end else if (hold_full_q) begin
                        // Last bit: chain the buffered word so the next frame follows with no gap.
                        shift_d     = hold_q;
                        hold_full_d = 1'b0;
                        cnt_d       = CNT_LAST;
                    end else if (handshake) begin
                        shift_d = bus.in_data;
                        cnt_d   = CNT_LAST;
                    end else begin
                        shift_d = '0;
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
        if (!reset) begin
            state_q     <= IDLE;
            shift_q     <= '0;
            cnt_q       <= '0;
            hold_full_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            cnt_q       <= cnt_d;
            hold_full_q <= hold_full_d;
        end
    end

    // NOTE: the holding buffer is plain data qualified by hold_full_q, so it carries no reset.
    always_ff @(posedge clk) begin
        hold_q <= hold_d;
    end
endmodule

// File: tb/tb_bit_serializer.sv
// Directed self-checking bench for bit_serializer: MSB-first instance for most cases,
// LSB-first instance for bit ordering.
module tb_bit_serializer;
    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    bit_serializer_if #(.WIDTH(8)) a_if ();
    bit_serializer_if #(.WIDTH(8)) b_if ();

    bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_msb (
        .clk   (clk),
        .reset (reset),
        .bus   (a_if)
    );

    bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_lsb (
        .clk   (clk),
        .reset (reset),
        .bus   (b_if)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Inputs change 1 ns after a rising edge; outputs are read at the same point.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer up to three words back to back with in_valid held, then check the contiguous MSB-first stream.
    task automatic stream_words(input string tag, input logic [7:0] w0, input logic [7:0] w1,
                                input logic [7:0] w2, input int n);
        logic [7:0] w[3];
        int         idx;
        bit         hs;
        w[0] = w0;
        w[1] = w1;
        w[2] = w2;
        a_if.in_data  = w[0];
        a_if.in_valid = 1'b1;
        step();
        idx = 1;
        for (int i = 0; i < 8 * n; i++) begin
            check({tag, "_valid"}, 32'(a_if.out_valid), 1);
            check({tag, "_bit"}, 32'(a_if.out_bit), 32'(w[i / 8][7 - (i % 8)]));
            check({tag, "_fs"}, 32'(a_if.frame_start), (i % 8 == 0) ? 1 : 0);
            if (n >= 2 && i >= 1 && i <= 8)
                check({tag, "_ready"}, 32'(a_if.in_ready), (i == 8) ? 1 : 0);
            a_if.in_valid = (idx < n);
            a_if.in_data  = (idx < n) ? w[idx] : 8'h00;
            hs = a_if.in_valid && a_if.in_ready;
            step();
            if (hs) idx++;
        end
        a_if.in_valid = 1'b0;
        check({tag, "_accepted"}, 32'(idx), 32'(n));
        check({tag, "_end_valid"}, 32'(a_if.out_valid), 0);
        check({tag, "_end_bit"}, 32'(a_if.out_bit), 0);
        check({tag, "_end_busy"}, 32'(a_if.busy), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] exp16;
        logic [7:0]  lsb_word;

        a_if.in_data  = '0;
        a_if.in_valid = 1'b0;
        a_if.abort    = 1'b0;
        b_if.in_data  = '0;
        b_if.in_valid = 1'b0;
        b_if.abort    = 1'b0;
        reset         = 1'b0;
        step();
        step();
        reset = 1'b1;
        step();

        // Reset state
        check("rst_ready", 32'(a_if.in_ready), 1);
        check("rst_bit", 32'(a_if.out_bit), 0);
        check("rst_valid", 32'(a_if.out_valid), 0);
        check("rst_fs", 32'(a_if.frame_start), 0);
        check("rst_busy", 32'(a_if.busy), 0);
        check("rst_lsb_valid", 32'(b_if.out_valid), 0);

        // Single word, then back-to-back pair, then a third word against a full buffer
        stream_words("single", 8'hB0, 8'h00, 8'h00, 1);
        stream_words("pair", 8'hB0, 8'h0B, 8'h00, 2);
        stream_words("triple", 8'h96, 8'h3C, 8'hE1, 3);

        // Bypass: second word offered exactly on the last bit with the buffer empty
        exp16 = 16'h5AA5;
        a_if.in_data  = 8'h5A;
        a_if.in_valid = 1'b1;
        step();
        a_if.in_valid = 1'b0;
        for (int i = 0; i < 16; i++) begin
            check("byp_valid", 32'(a_if.out_valid), 1);
            check("byp_bit", 32'(a_if.out_bit), 32'(exp16[15 - i]));
            check("byp_fs", 32'(a_if.frame_start), (i % 8 == 0) ? 1 : 0);
            if (i == 7) begin
                check("byp_ready", 32'(a_if.in_ready), 1);
                a_if.in_valid = 1'b1;
                a_if.in_data  = 8'hA5;
            end
            step();
            a_if.in_valid = 1'b0;
        end
        check("byp_end_valid", 32'(a_if.out_valid), 0);

        // Reset on bit 4 of 0xFF with 0x33 buffered
        a_if.in_data  = 8'hFF;
        a_if.in_valid = 1'b1;
        step();
        a_if.in_data = 8'h33;
        step();
        a_if.in_valid = 1'b0;
        check("mid_busy", 32'(a_if.busy), 1);
        check("mid_ready", 32'(a_if.in_ready), 0);
        step();
        step();
        check("mid_bit4", 32'(a_if.out_bit), 1);
        reset = 1'b0;
        step();
        check("mrst_valid", 32'(a_if.out_valid), 0);
        check("mrst_busy", 32'(a_if.busy), 0);
        check("mrst_ready", 32'(a_if.in_ready), 1);
        check("mrst_bit", 32'(a_if.out_bit), 0);
        check("mrst_fs", 32'(a_if.frame_start), 0);
        reset = 1'b1;
        step();
        check("mrst_after_valid", 32'(a_if.out_valid), 0);
        stream_words("rst_next", 8'h81, 8'h00, 8'h00, 1);

        // Abort on bit 2 with a same-cycle handshake
        a_if.in_data  = 8'hC3;
        a_if.in_valid = 1'b1;
        step();
        a_if.in_valid = 1'b0;
        step();
        check("abt_bit2", 32'(a_if.out_bit), 1);
        check("abt_ready", 32'(a_if.in_ready), 1);
        a_if.abort    = 1'b1;
        a_if.in_valid = 1'b1;
        a_if.in_data  = 8'h7E;
        step();
        a_if.abort    = 1'b0;
        a_if.in_valid = 1'b0;
        check("abt_valid", 32'(a_if.out_valid), 0);
        check("abt_busy", 32'(a_if.busy), 0);
        check("abt_ready_after", 32'(a_if.in_ready), 1);
        check("abt_fs", 32'(a_if.frame_start), 0);
        for (int i = 0; i < 10; i++) begin
            step();
            check("abt_dropped", 32'(a_if.out_valid), 0);
        end

        // LSB-first instance: 0x0D -> 1,0,1,1,0,0,0,0
        lsb_word = 8'h0D;
        b_if.in_data  = lsb_word;
        b_if.in_valid = 1'b1;
        step();
        b_if.in_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check("lsb_valid", 32'(b_if.out_valid), 1);
            check("lsb_bit", 32'(b_if.out_bit), 32'(lsb_word[i]));
            check("lsb_fs", 32'(b_if.frame_start), (i == 0) ? 1 : 0);
            step();
        end
        check("lsb_end_valid", 32'(b_if.out_valid), 0);
        check("lsb_end_busy", 32'(b_if.busy), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/bit_serializer.md
BIT_SERIALIZER -- requirements
Module: bit_serializer

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning the word length in bits (legal range 2..32).
REQ-002 SHALL have parameter MSB_FIRST, default 1, meaning 1 = send bit WIDTH-1 first and 0 = send bit 0 first.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-004 SHALL have port reset, input, 1, the reset; it is synchronous and active-low (0 = reset).
REQ-005 SHALL have port in_data, input, WIDTH, the parallel word to serialize.
REQ-006 SHALL have port in_valid, input, 1, meaning in_data is valid.
REQ-007 SHALL have port in_ready, output, 1, meaning the block can accept a word this cycle.
REQ-008 SHALL have port abort, input, 1, a synchronous flush of all pending bits.
REQ-009 SHALL have port out_bit, output, 1, the serial bit for the downstream sequence detector's inp_bit.
REQ-010 SHALL have port out_valid, output, 1, meaning out_bit carries word data.
REQ-011 SHALL have port frame_start, output, 1, high on the first bit of each word.
REQ-012 SHALL have port busy, output, 1, meaning shifting is in progress or a word is buffered.

Function
REQ-013 SHALL have FSM states IDLE (shift register empty) and SHIFT (emitting bits).
REQ-014 SHALL hold a shift register, a bit counter (cnt, 0..WIDTH-1) and a one-word holding buffer with flag hold_full.
REQ-015 SHALL drive in_ready = !hold_full, derived from registers only with no combinational path from in_valid.
REQ-016 SHALL define a handshake as in_valid && in_ready at a rising edge; in_data is captured at that edge.
REQ-017 SHALL, on a handshake in IDLE, load the word into the shift register, set cnt = WIDTH-1 and go to SHIFT.
REQ-018 SHALL give a latency of one cycle: the first bit appears on out_bit in the cycle after the accepting edge.
REQ-019 SHALL, in SHIFT, drive out_valid = 1 and out_bit = shift[WIDTH-1] when MSB_FIRST=1, else shift[0].
REQ-020 SHALL, in SHIFT, shift one position per cycle toward the output end and decrement cnt.
REQ-021 SHALL drive frame_start = 1 exactly when state = SHIFT and cnt = WIDTH-1.
REQ-022 SHALL, on a handshake in SHIFT with cnt != 0, write the word into the holding buffer and set hold_full.
REQ-023 SHALL, on the last bit (cnt = 0) with hold_full = 1, move the buffer into the shift register, clear hold_full, set cnt = WIDTH-1 and stay in SHIFT with no gap.
REQ-024 SHALL, on the last bit with hold_full = 0 and a same-cycle handshake, load in_data directly into the shift register (bypass), leave hold_full = 0 and stay in SHIFT with no gap.
REQ-025 SHALL, on the last bit with hold_full = 0 and no handshake, return to IDLE.
REQ-026 SHALL drive out_bit = 0 and out_valid = 0 in IDLE, so the detector sees zeros between frames.
REQ-027 SHALL drive busy = (state = SHIFT) || hold_full.
REQ-028 SHALL, with abort = 1 at an edge, go to IDLE, clear hold_full and cnt, and drop any same-cycle handshake, while still reporting in_ready per REQ-015.
REQ-029 SHALL NOT modify, reorder or drop a word once it has been accepted, except on abort or reset.

Reset
REQ-030 SHALL, with reset = 0 at a rising edge, set state = IDLE, hold_full = 0, cnt = 0 and shift register = 0.
REQ-031 SHALL produce these output values after reset: in_ready = 1, out_bit = 0, out_valid = 0, frame_start = 0, busy = 0.
REQ-032 SHALL give reset priority over abort and handshakes, and on reset mid-word SHALL discard that word and any buffered word.
REQ-033 SHALL NOT produce a partial word after reset is released; the first word accepted after reset starts with frame_start = 1.

Verification (WIDTH=8 unless stated)
REQ-034 SHALL cover: MSB_FIRST=1, single word 0xB0 -> out_bit 1,0,1,1,0,0,0,0 on cycles 1..8, frame_start on cycle 1 only, then IDLE with out_valid = 0.
REQ-035 SHALL cover: 0xB0 then 0x0B with in_valid held high -> 16 contiguous valid bits 10110000 00001011 and frame_start on cycles 1 and 9.
REQ-036 SHALL cover: third word offered while the buffer is full -> in_ready = 0 until the buffered word moves to the shift register, then the word is accepted and no word is lost.
REQ-037 SHALL cover: MSB_FIRST=0, word 0x0D -> out_bit 1,0,1,1,0,0,0,0.
REQ-038 SHALL cover: reset = 0 asserted on bit 4 of 0xFF with a word buffered -> next cycle out_valid = 0, busy = 0, in_ready = 1, and the next word restarts cleanly.
REQ-039 SHALL cover: abort on bit 2 with a same-cycle handshake -> IDLE next cycle and the handshaken word is not emitted.
